pwm_duty_meter: RTL and testbench

- Receive-side counterpart of the team's PWM LED generator.
- Samples an external PWM waveform and measures high time and period in clk cycles.
- Converts the measurement to a DUTY_W-bit duty code on the same scale the generator uses (0 .. 2^DUTY_W-1).
- Used for loopback self-test of PWM outputs and for reading duty from external PWM sources.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_div.sv | 82 ++++++++
 rtl/pwm_duty_meter.sv | 152 +++++++++++++++
 tb/tb_pwm_duty_meter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / duty meter pair.
package pwm_pkg;

  // Both ends of a PWM link use these widths so duty codes mean the same thing.
  localparam int unsigned DefaultCntW  = 16;
  localparam int unsigned DefaultDutyW = 10;

  // Duty meter measurement FSM.
  typedef enum logic [0:0] {
    StIdle,
    StMeas
  } meas_state_e;

endpackage

// File: rtl/pwm_div.sv
// Sequential restoring divider producing a DUTY_W-bit quotient of num / den.
// The upper CNT_W bits of num are expected to be below den, so only DUTY_W
// quotient bits are generated; anything else saturates to all ones.
module pwm_div
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W  = DefaultCntW,
  parameter int unsigned DUTY_W = DefaultDutyW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W+DUTY_W-1:0] num,
  input  logic [CNT_W-1:0]        den,
  output logic [DUTY_W-1:0]       quotient,
  output logic                    done,
  output logic                    busy
);

  localparam int unsigned IterW = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;
  localparam logic [IterW-1:0] LastIter = IterW'(DUTY_W - 1);

  logic              busy_q;
  logic              sat_q;
  logic [IterW-1:0]  iter_q;
  logic [CNT_W-1:0]  rem_q;
  logic [CNT_W-1:0]  den_q;
  logic [DUTY_W-1:0] low_q;
  logic [DUTY_W-1:0] quo_q;

  logic [CNT_W:0]    rem_sh;
  logic              q_bit;
  logic [CNT_W-1:0]  rem_nx;
  logic [DUTY_W-1:0] quo_nx;
  logic [DUTY_W-1:0] low_nx;
  logic [CNT_W-1:0]  num_hi;

  assign num_hi = num[CNT_W+DUTY_W-1:DUTY_W];

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, low_q[DUTY_W-1]};
    q_bit  = (rem_sh >= {1'b0, den_q});
    rem_nx = q_bit ? CNT_W'(rem_sh - {1'b0, den_q}) : rem_sh[CNT_W-1:0];
    quo_nx = (quo_q << 1) | DUTY_W'(q_bit);
    low_nx = low_q << 1;
  end

  assign done     = busy_q && (iter_q == LastIter);
  assign quotient = sat_q ? {DUTY_W{1'b1}} : quo_nx;
  assign busy     = busy_q;

  // Operand load on start, then one quotient bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      sat_q  <= 1'b0;
      iter_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      low_q  <= '0;
      quo_q  <= '0;
    end else if (start && !busy_q) begin
      busy_q <= 1'b1;
      sat_q  <= (num_hi >= den);
      iter_q <= '0;
      rem_q  <= (num_hi >= den) ? '0 : num_hi;
      den_q  <= den;
      low_q  <= num[DUTY_W-1:0];
      quo_q  <= '0;
    end else if (busy_q) begin
      rem_q  <= rem_nx;
      low_q  <= low_nx;
      quo_q  <= quo_nx;
      iter_q <= iter_q + IterW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of an external PWM waveform and converts them
// to a duty code on the generator's 0 .. 2^DUTY_W-1 scale.
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W  = DefaultCntW,
  parameter int unsigned DUTY_W = DefaultDutyW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [DUTY_W-1:0] DutyMax = {DUTY_W{1'b1}};

  logic sync_q, s_q, s_d_q;
  logic rise;

  meas_state_e      state_q;
  logic [CNT_W-1:0] acc_p_q, acc_h_q;
  logic [CNT_W-1:0] h_op_q, p_op_q;

  logic res_valid_q;
  logic stuck_pend_q;
  logic stuck_lvl_q;

  logic              close_evt, start, timeout, stuck_req, stuck_lvl;
  logic              div_done, div_busy;
  logic [DUTY_W-1:0] div_quo;

  assign rise      = s_q & ~s_d_q;
  // Busy spans the result cycle too, so a close landing there is dropped.
  assign busy      = div_busy | res_valid_q;
  assign close_evt = (state_q == StMeas) && rise;
  assign start     = close_evt && !busy;
  assign timeout   = (state_q == StMeas) && !rise && (acc_p_q == CntMax);
  assign stuck_req = timeout | stuck_pend_q;
  assign stuck_lvl = timeout ? s_q : stuck_lvl_q;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      s_q    <= 1'b0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= pwm_in;
      s_q    <= sync_q;
      s_d_q  <= s_q;
    end
  end

  // Measurement FSM: accumulate high time and period between rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_p_q <= '0;
      acc_h_q <= '0;
      h_op_q  <= '0;
      p_op_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            acc_p_q <= CntOne;
            acc_h_q <= CntOne;
            state_q <= StMeas;
          end
        end
        StMeas: begin
          if (rise) begin
            if (start) begin
              h_op_q <= acc_h_q;
              p_op_q <= acc_p_q;
            end
            acc_p_q <= CntOne;
            acc_h_q <= CntOne;
          end else if (acc_p_q == CntMax) begin
            state_q <= StIdle;
          end else begin
            acc_p_q <= acc_p_q + CntOne;
            if (s_q) begin
              acc_h_q <= acc_h_q + CntOne;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pwm_div #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num      ({acc_h_q, {DUTY_W{1'b0}}}),
    .den      (acc_p_q),
    .quotient (div_quo),
    .done     (div_done),
    .busy     (div_busy)
  );

  // Result registers; a stuck report waits until any running divide has reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_cnt     <= '0;
      period_cnt   <= '0;
      duty         <= '0;
      valid        <= 1'b0;
      stuck        <= 1'b0;
      res_valid_q  <= 1'b0;
      stuck_pend_q <= 1'b0;
      stuck_lvl_q  <= 1'b0;
    end else begin
      valid       <= 1'b0;
      res_valid_q <= 1'b0;
      if (timeout) begin
        stuck_lvl_q <= s_q;
      end
      if (div_done) begin
        high_cnt    <= h_op_q;
        period_cnt  <= p_op_q;
        duty        <= div_quo;
        stuck       <= 1'b0;
        valid       <= 1'b1;
        res_valid_q <= 1'b1;
        if (stuck_req) begin
          stuck_pend_q <= 1'b1;
        end
      end else if (stuck_req && !div_busy) begin
        duty         <= stuck_lvl ? DutyMax : '0;
        stuck        <= 1'b1;
        valid        <= 1'b1;
        stuck_pend_q <= 1'b0;
      end else if (stuck_req) begin
        stuck_pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: the stimulus side predicts each report
// from the edge times it drives; a monitor pops and compares on every valid.
module tb_pwm_duty_meter;

  // Narrower counters keep the timeout scenarios short.
  localparam int CNT_W    = 12;
  localparam int DUTY_W   = 10;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int DUTY_MAX = (1 << DUTY_W) - 1;
  localparam int MIN_GAP  = DUTY_W + 2;

  logic              clk;
  logic              rst;
  logic              pwm_in;
  logic [CNT_W-1:0]  high_cnt;
  logic [CNT_W-1:0]  period_cnt;
  logic [DUTY_W-1:0] duty;
  logic              valid;
  logic              stuck;
  logic              busy;

  pwm_duty_meter #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .duty       (duty),
    .valid      (valid),
    .stuck      (stuck),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     h;
    int     p;
    int     d;
    int     st;
    longint vcyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_valid = 0;

  // Stimulus-side model of the measurement.
  bit     cur_lvl;
  bit     m_meas;
  longint m_rise, m_fall, m_last_acc;
  int     m_last_h, m_last_p;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int duty_of(input int h, input int p);
    longint q;
    q = (longint'(h) << DUTY_W) / p;
    if (q > DUTY_MAX) q = DUTY_MAX;
    return int'(q);
  endfunction

  // Drive pwm_in at a falling clock edge; a rise closes the previous period.
  task automatic set_pwm(input bit lvl);
    exp_t e;
    int   hh, pp;
    @(negedge clk);
    if (lvl && !cur_lvl) begin
      if (m_meas) begin
        pp = int'(cyc - m_rise);
        hh = int'(m_fall - m_rise);
        if (cyc - m_last_acc >= MIN_GAP) begin
          e.h    = hh;
          e.p    = pp;
          e.d    = duty_of(hh, pp);
          e.st   = 0;
          // 3 cycles of sync/edge detect, DUTY_W+1 to the valid cycle, minus 1 for sampling.
          e.vcyc = cyc + DUTY_W + 3;
          sb.push_back(e);
          m_last_acc = cyc;
          m_last_h   = hh;
          m_last_p   = pp;
        end
      end
      m_meas = 1'b1;
      m_rise = cyc;
    end else if (!lvl && cur_lvl) begin
      m_fall = cyc;
    end
    pwm_in  = lvl;
    cur_lvl = lvl;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic period(input int h, input int l);
    set_pwm(1'b1);
    wait_cyc(h - 1);
    set_pwm(1'b0);
    wait_cyc(l - 1);
  endtask

  task automatic expect_stuck(input bit lvl);
    exp_t e;
    e.h    = m_last_h;
    e.p    = m_last_p;
    e.d    = lvl ? DUTY_MAX : 0;
    e.st   = 1;
    e.vcyc = -1;
    sb.push_back(e);
    m_meas = 1'b0;
  endtask

  // Monitor: every valid must match the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq("high_cnt", high_cnt, e.h);
        check_eq("period_cnt", period_cnt, e.p);
        check_eq("duty", duty, e.d);
        check_eq("stuck", stuck, e.st);
        if (e.vcyc >= 0) check_eq("valid_latency", cyc, e.vcyc);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst        = 1'b1;
    pwm_in     = 1'b0;
    cur_lvl    = 1'b0;
    m_meas     = 1'b0;
    m_rise     = 0;
    m_fall     = 0;
    m_last_acc = -1000;
    m_last_h   = 0;
    m_last_p   = 0;
    wait_cyc(3);
    check_eq("rst_high_cnt", high_cnt, 0);
    check_eq("rst_period_cnt", period_cnt, 0);
    check_eq("rst_duty", duty, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_stuck", stuck, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    wait_cyc(2);

    // First rise alone, then a long high below timeout: no report.
    set_pwm(1'b1);
    wait_cyc(299);
    check_eq("first_edge_no_valid", n_valid, 0);
    set_pwm(1'b0);
    wait_cyc(699);

    // 25% duty.
    repeat (5) period(250, 750);
    // 1/3 duty, floor rounding.
    repeat (6) period(100, 200);

    // Stuck low, then recover at 50%.
    expect_stuck(1'b0);
    wait_cyc(CNT_MAX + 300);
    check_eq("stuck_low_level", stuck, 1);
    check_eq("stuck_low_duty", duty, 0);
    repeat (2) period(500, 500);

    // Stuck high.
    set_pwm(1'b1);
    expect_stuck(1'b1);
    wait_cyc(CNT_MAX + 300);
    check_eq("stuck_high_level", stuck, 1);
    check_eq("stuck_high_duty", duty, DUTY_MAX);
    set_pwm(1'b0);
    wait_cyc(50);

    // Periods shorter than the divide: only closes that find the divider idle report.
    repeat (15) period(2, 3);
    wait_cyc(30);

    // Reset during a divide.
    set_pwm(1'b1);
    wait_cyc(5);
    check_eq("busy_before_rst", busy, 1);
    rst     = 1'b1;
    pwm_in  = 1'b0;
    cur_lvl = 1'b0;
    #1;
    check_eq("async_rst_high_cnt", high_cnt, 0);
    check_eq("async_rst_period_cnt", period_cnt, 0);
    check_eq("async_rst_duty", duty, 0);
    check_eq("async_rst_valid", valid, 0);
    check_eq("async_rst_stuck", stuck, 0);
    check_eq("async_rst_busy", busy, 0);
    sb.delete();
    m_meas     = 1'b0;
    m_last_acc = -1000;
    m_last_h   = 0;
    m_last_p   = 0;
    @(negedge clk);
    rst  = 1'b0;
    snap = n_valid;
    wait_cyc(40);
    check_eq("no_valid_after_rst", n_valid - snap, 0);
    set_pwm(1'b1);
    wait_cyc(99);
    set_pwm(1'b0);
    wait_cyc(199);
    check_eq("no_valid_one_rise", n_valid - snap, 0);
    repeat (3) period(100, 200);

    // Drain outstanding predictions.
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check_eq("scoreboard_drained", sb.size(), 0);
    check_eq("hold_high_cnt", high_cnt, 100);
    check_eq("hold_period_cnt", period_cnt, 300);
    check_eq("hold_duty", duty, 341);
    check_eq("hold_stuck", stuck, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
